operand_accumulator: RTL and testbench

OPERAND_ACCUMULATOR -- requirements
Module: operand_accumulator

---
 rtl/operand_accumulator.sv | 104 ++++++++++
 tb/tb_operand_accumulator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_accumulator.sv
// Operand accumulator: sums `count` 32-bit operands with a sticky carry-out flag.
// Define OPERAND_ACCUMULATOR_SATURATE_EN to clamp at 32'hFFFF_FFFF on overflow instead of wrapping.
module operand_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_sum,
    output logic             out_carry,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic [32:0]      add_full;
    logic [31:0]      add_sum;
    logic             add_cout;

    assign add_full = {1'b0, acc_q} + {1'b0, in_data};
    assign add_sum  = add_full[31:0];
    assign add_cout = add_full[32];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        remaining_d = remaining_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = 32'd0;
                    carry_d = 1'b0;
                    if (count != '0) begin
                        remaining_d = count;
                        state_d     = ACCUM;
                    end else begin
                        remaining_d = '0;
                        state_d     = DONE;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
`ifdef OPERAND_ACCUMULATOR_SATURATE_EN
                    // Once any add has overflowed, the result is pinned at full scale.
                    acc_d = (add_cout || carry_q) ? 32'hFFFF_FFFF : add_sum;
`else
                    acc_d = add_sum;
`endif
                    carry_d     = carry_q | add_cout;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 32'd0;
            carry_q     <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            remaining_q <= remaining_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_operand_accumulator.sv
// Directed bench for operand_accumulator with a result scoreboard queue.
module tb_operand_accumulator;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_sum;
    logic             out_carry;
    logic             out_ready;
    logic             busy;

    operand_accumulator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          xfers = 0;
    logic [31:0] model_acc;
    logic        model_carry;
    logic [32:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] check %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic begin_acc(input logic [CNT_W-1:0] cnt);
        start       = 1'b1;
        count       = cnt;
        model_acc   = 32'd0;
        model_carry = 1'b0;
        xfers       = 0;
        step();
        start = 1'b0;
    endtask

    // Reference add: wrap or saturate on carry-out, carry flag is sticky.
    task automatic send(input logic [31:0] d, input int gap);
        logic [32:0] s;
        in_valid = 1'b1;
        in_data  = d;
        if (in_ready === 1'b1) begin
            xfers++;
            s = {1'b0, model_acc} + {1'b0, d};
`ifdef OPERAND_ACCUMULATOR_SATURATE_EN
            model_acc = (s[32] || model_carry) ? 32'hFFFF_FFFF : s[31:0];
`else
            model_acc = s[31:0];
`endif
            model_carry = model_carry | s[32];
        end
        step();
        in_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic collect(input string tag);
        int          n;
        logic [32:0] e;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        tests++;
        assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, out_sum, e[31:0]);
            check({tag, "_carry"}, {31'd0, out_carry}, {31'd0, e[32]});
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0;
        in_data = 32'd0; out_ready = 1'b0;
        model_acc = 32'd0; model_carry = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_out_carry", {31'd0, out_carry}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // 5 + 7 + 9 back-to-back, result one cycle after last accept
        begin_acc(8'd3);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send(32'd5, 0);
        send(32'd7, 0);
        check("t1_no_early_valid", {31'd0, out_valid}, 32'd0);
        send(32'd9, 0);
        exp_q.push_back({1'b0, 32'd21});
        check("t1_latency", {31'd0, out_valid}, 32'd1);
        collect("t1");
        handshake("t1");

        // Overflow behaviour
        begin_acc(8'd2);
        send(32'hFFFF_FFFF, 0);
        send(32'd2, 0);
`ifdef OPERAND_ACCUMULATOR_SATURATE_EN
        exp_q.push_back({1'b1, 32'hFFFF_FFFF});
`else
        exp_q.push_back({1'b1, 32'd1});
`endif
        collect("t2");
        handshake("t2");

        // count == 0 goes straight to DONE; outputs hold and start is ignored
        begin_acc(8'd0);
        exp_q.push_back({1'b0, 32'd0});
        check("t3_done_next", {31'd0, out_valid}, 32'd1);
        collect("t3");
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            count = 8'd5;
            step();
            check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t3_hold_sum", out_sum, 32'd0);
            check("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        count = 8'd1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        check("t3_start_ignored_busy", {31'd0, busy}, 32'd0);

        // Gapped input 1-on/2-off; extra valid beat after DONE must not transfer
        begin_acc(8'd4);
        send(32'd1, 2);
        send(32'd2, 2);
        send(32'd3, 2);
        send(32'd4, 0);
        exp_q.push_back({model_carry, model_acc});
        in_valid = 1'b1;
        in_data  = 32'd100;
        check("t4_in_ready_done", {31'd0, in_ready}, 32'd0);
        step();
        in_valid = 1'b0;
        check("t4_xfers", xfers, 32'd4);
        check("t4_expect_sum", model_acc, 32'd10);
        collect("t4");
        handshake("t4");

        // Reset mid-accumulation, with start and in_valid asserted alongside
        begin_acc(8'd4);
        send(32'd11, 0);
        send(32'd22, 0);
        rst = 1'b1; start = 1'b1; count = 8'd3; in_valid = 1'b1; in_data = 32'd5;
        step();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_sum", out_sum, 32'd0);
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
        begin_acc(8'd1);
        send(32'h10, 0);
        exp_q.push_back({1'b0, 32'h10});
        collect("t5");
        handshake("t5");

        // Random operands against the reference model
        for (int r = 0; r < 3; r++) begin
            begin_acc(8'd6);
            for (int k = 0; k < 6; k++) begin
                send($urandom(), $urandom_range(0, 1));
            end
            exp_q.push_back({model_carry, model_acc});
            collect("rnd");
            handshake("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
